draw_rect_stream: RTL and testbench

//  Rectangle rasteriser, parametrised successor to the fixed 8-bit outline walker.

---
 rtl/draw_rect_stream_if.sv | 12 +
 rtl/draw_rect_stream.sv | 163 ++++++++++++++++
 tb/tb_draw_rect_stream.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_rect_stream_if.sv
// rtl/draw_rect_stream_if.sv - pixel stream handshake bundle for draw_rect_stream
interface draw_rect_stream_if #(
  parameter int CW = 8
);
  logic          PIX_VALID;
  logic          PIX_READY;
  logic [CW-1:0] X_Out;
  logic [CW-1:0] Y_Out;

  modport master (output PIX_VALID, output X_Out, output Y_Out, input PIX_READY);
  modport slave  (input PIX_VALID, input X_Out, input Y_Out, output PIX_READY);
endinterface

// File: rtl/draw_rect_stream.sv
// rtl/draw_rect_stream.sv - rectangle rasteriser emitting outline or filled pixel coordinates
module draw_rect_stream #(
  parameter int CW      = 8,
  parameter bit FILL_EN = 1'b1
) (
  input  logic                ACLK,
  input  logic                RST,
  input  logic                START,
  input  logic                MODE,
  input  logic [CW-1:0]       X_0,
  input  logic [CW-1:0]       Y_0,
  input  logic [CW-1:0]       X_1,
  input  logic [CW-1:0]       Y_1,
  output logic                BUSY,
  output logic                FINISH,
  draw_rect_stream_if.master  pix
);

  typedef enum logic [2:0] {
    S_IDLE, S_TOP, S_RIGHT, S_BOTTOM, S_LEFT, S_RASTER, S_DONE
  } state_t;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [CW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;

  logic [CW-1:0] in_xmin, in_xmax, in_ymin, in_ymax;
  logic [CW-1:0] x_inc, x_dec, y_inc, y_dec;
  logic          fill_sel;
  logic          pix_valid;
  logic          xfer;

  // Corner ordering and step values; counters compare against bounds so they never wrap
  always_comb begin
    in_xmin  = (X_0 < X_1) ? X_0 : X_1;
    in_xmax  = (X_0 < X_1) ? X_1 : X_0;
    in_ymin  = (Y_0 < Y_1) ? Y_0 : Y_1;
    in_ymax  = (Y_0 < Y_1) ? Y_1 : Y_0;
    fill_sel = FILL_EN & MODE;
    x_inc    = x_q + ONE;
    x_dec    = x_q - ONE;
    y_inc    = y_q + ONE;
    y_dec    = y_q - ONE;
    xfer     = pix_valid & pix.PIX_READY;
  end

  // State and datapath registers
  always_ff @(posedge ACLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Next state and pixel walk; pixel only advances on a completed transfer
  always_comb begin
    state_d = state_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          xmin_d = in_xmin;
          xmax_d = in_xmax;
          ymin_d = in_ymin;
          ymax_d = in_ymax;
          x_d    = in_xmin;
          y_d    = in_ymin;
          // A zero-width or zero-height outline is a line or point: raster covers it once
          if (fill_sel || (in_xmin == in_xmax) || (in_ymin == in_ymax)) begin
            state_d = S_RASTER;
          end else begin
            state_d = S_TOP;
          end
        end
      end
      S_TOP: begin
        if (xfer) begin
          x_d = x_inc;
          if (x_inc == xmax_q) state_d = S_RIGHT;
        end
      end
      S_RIGHT: begin
        if (xfer) begin
          y_d = y_inc;
          if (y_inc == ymax_q) state_d = S_BOTTOM;
        end
      end
      S_BOTTOM: begin
        if (xfer) begin
          x_d = x_dec;
          if (x_dec == xmin_q) state_d = S_LEFT;
        end
      end
      S_LEFT: begin
        if (xfer) begin
          if (y_dec == ymin_q) begin
            state_d = S_DONE;
          end else begin
            y_d = y_dec;
          end
        end
      end
      S_RASTER: begin
        if (xfer) begin
          if (x_q != xmax_q) begin
            x_d = x_inc;
          end else if (y_q != ymax_q) begin
            x_d = xmin_q;
            y_d = y_inc;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    BUSY      = 1'b0;
    FINISH    = 1'b0;
    pix_valid = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_DONE: begin
        BUSY   = 1'b1;
        FINISH = 1'b1;
      end
      default: begin
        BUSY      = 1'b1;
        pix_valid = 1'b1;
      end
    endcase
  end

  assign pix.PIX_VALID = pix_valid;
  assign pix.X_Out     = x_q;
  assign pix.Y_Out     = y_q;

endmodule

// File: tb/tb_draw_rect_stream.sv
// tb/tb_draw_rect_stream.sv - directed self-checking bench for draw_rect_stream
module tb_draw_rect_stream;
  localparam int CW = 8;

  logic          ACLK  = 1'b0;
  logic          RST   = 1'b1;
  logic          START = 1'b0;
  logic          MODE  = 1'b0;
  logic [CW-1:0] X_0 = '0, Y_0 = '0, X_1 = '0, Y_1 = '0;
  logic          ready = 1'b0;
  logic          sel   = 1'b0;
  logic          busy0, busy1, fin0, fin1;

  draw_rect_stream_if #(.CW(CW)) pix0 ();
  draw_rect_stream_if #(.CW(CW)) pix1 ();

  assign pix0.PIX_READY = ready;
  assign pix1.PIX_READY = ready;

  draw_rect_stream #(.CW(CW), .FILL_EN(1'b1)) dut0 (
    .ACLK(ACLK), .RST(RST), .START(START), .MODE(MODE),
    .X_0(X_0), .Y_0(Y_0), .X_1(X_1), .Y_1(Y_1),
    .BUSY(busy0), .FINISH(fin0), .pix(pix0)
  );

  draw_rect_stream #(.CW(CW), .FILL_EN(1'b0)) dut1 (
    .ACLK(ACLK), .RST(RST), .START(START), .MODE(MODE),
    .X_0(X_0), .Y_0(Y_0), .X_1(X_1), .Y_1(Y_1),
    .BUSY(busy1), .FINISH(fin1), .pix(pix1)
  );

  always #5 ACLK = ~ACLK;

  wire          pv  = sel ? pix1.PIX_VALID : pix0.PIX_VALID;
  wire [CW-1:0] px  = sel ? pix1.X_Out : pix0.X_Out;
  wire [CW-1:0] py  = sel ? pix1.Y_Out : pix0.Y_Out;
  wire          bsy = sel ? busy1 : busy0;
  wire          fin = sel ? fin1 : fin0;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] px_x[$], px_y[$];
  logic [2*CW-1:0] exp_q[$];
  int   fin_cnt, fin_cyc, last_xfer, hold_bad, gap_bad;
  logic busy_at_fin, valid_at_fin, busy_after, timed_out;

  function automatic logic [2*CW-1:0] pk(input int x, input int y);
    logic [CW-1:0] xs, ys;
    xs = x[CW-1:0];
    ys = y[CW-1:0];
    return {xs, ys};
  endfunction

  // Issue a command; returns one cycle later with the first pixel presented
  task automatic start_cmd(input int x0, input int y0, input int x1, input int y1, input logic m);
    X_0 = x0[CW-1:0]; Y_0 = y0[CW-1:0]; X_1 = x1[CW-1:0]; Y_1 = y1[CW-1:0]; MODE = m;
    START = 1'b1;
    @(posedge ACLK); #1;
    START = 1'b0;
  endtask

  // Record the pixel stream of the selected instance until one cycle after FINISH
  task automatic collect(input int stall_after, input int stall_len, input int inject_at);
    int stall_left;
    bit stall_used, hold_chk, fin_seen;
    logic [CW-1:0] hx, hy;
    px_x.delete(); px_y.delete();
    fin_cnt = 0; fin_cyc = -1; last_xfer = -1; hold_bad = 0; gap_bad = 0;
    busy_at_fin = 1'b0; valid_at_fin = 1'b1; busy_after = 1'b1; timed_out = 1'b1;
    stall_left = 0; stall_used = 0; hold_chk = 0; fin_seen = 0; hx = '0; hy = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (hold_chk && (!pv || px !== hx || py !== hy)) hold_bad++;
      hold_chk = 0;
      if (fin_seen) begin
        busy_after = bsy;
        timed_out  = 1'b0;
        break;
      end
      if (!stall_used && stall_len > 0 && px_x.size() == stall_after) begin
        stall_left = stall_len;
        stall_used = 1;
      end
      ready = (stall_left == 0);
      if (cyc == inject_at) begin
        X_0 = 8'd0; Y_0 = 8'd0; X_1 = 8'd1; Y_1 = 8'd1; MODE = 1'b1;
        START = 1'b1;
      end else begin
        START = 1'b0;
      end
      if (pv && ready) begin
        if (stall_len == 0 && last_xfer >= 0 && cyc != last_xfer + 1) gap_bad++;
        px_x.push_back(px);
        px_y.push_back(py);
        last_xfer = cyc;
      end
      if (pv && !ready) begin
        hold_chk = 1; hx = px; hy = py;
      end
      if (fin) begin
        fin_cnt++; fin_cyc = cyc; busy_at_fin = bsy; valid_at_fin = pv; fin_seen = 1;
      end
      if (stall_left > 0) stall_left--;
      @(posedge ACLK); #1;
    end
    START = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b1; ready = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy0); end
    checks++; if (pix0.PIX_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", pix0.PIX_VALID); end
    checks++; if (fin0 !== 1'b0) begin errors++; $display("FAIL reset_finish got %0b want 0", fin0); end
    checks++; if (pix0.X_Out !== 8'd0 || pix0.Y_Out !== 8'd0) begin
      errors++; $display("FAIL reset_xy got (%0d,%0d) want (0,0)", pix0.X_Out, pix0.Y_Out);
    end
    RST = 1'b0;
    @(posedge ACLK); #1;
  endtask

  task automatic test_outline;
    sel = 1'b0;
    start_cmd(2, 3, 5, 5, 1'b0);
    checks++; if (busy0 !== 1'b1 || pix0.PIX_VALID !== 1'b1) begin
      errors++; $display("FAIL outline_first_cycle got busy=%0b valid=%0b want 1 1", busy0, pix0.PIX_VALID);
    end
    collect(0, 0, -1);
    exp_q = '{pk(2,3), pk(3,3), pk(4,3), pk(5,3), pk(5,4), pk(5,5), pk(4,5), pk(3,5), pk(2,5), pk(2,4)};
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL outline_timeout got %0b want 0", timed_out); end
    checks++; if (px_x.size() != exp_q.size()) begin errors++; $display("FAIL outline_count got %0d want %0d", px_x.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= px_x.size() || {px_x[i], px_y[i]} !== exp_q[i]) begin
        errors++; $display("FAIL outline_pix%0d got (%0d,%0d) want (%0d,%0d)", i, px_x[i], px_y[i], exp_q[i][15:8], exp_q[i][7:0]);
      end
    end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL outline_bubbles got %0d want 0", gap_bad); end
    checks++; if (fin_cnt != 1 || fin_cyc != last_xfer + 1) begin
      errors++; $display("FAIL outline_finish got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", fin_cnt, fin_cyc, last_xfer + 1);
    end
    checks++; if (busy_at_fin !== 1'b1 || valid_at_fin !== 1'b0) begin
      errors++; $display("FAIL outline_done_state got busy=%0b valid=%0b want 1 0", busy_at_fin, valid_at_fin);
    end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL outline_busy_drop got %0b want 0", busy_after); end
    checks++; if (pix0.X_Out !== 8'd2 || pix0.Y_Out !== 8'd4) begin
      errors++; $display("FAIL outline_hold_last got (%0d,%0d) want (2,4)", pix0.X_Out, pix0.Y_Out);
    end
  endtask

  task automatic test_swapped;
    sel = 1'b0;
    start_cmd(5, 5, 2, 3, 1'b0);
    collect(0, 0, -1);
    exp_q = '{pk(2,3), pk(3,3), pk(4,3), pk(5,3), pk(5,4), pk(5,5), pk(4,5), pk(3,5), pk(2,5), pk(2,4)};
    checks++; if (px_x.size() != exp_q.size()) begin errors++; $display("FAIL swapped_count got %0d want %0d", px_x.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= px_x.size() || {px_x[i], px_y[i]} !== exp_q[i]) begin
        errors++; $display("FAIL swapped_pix%0d got (%0d,%0d) want (%0d,%0d)", i, px_x[i], px_y[i], exp_q[i][15:8], exp_q[i][7:0]);
      end
    end
    checks++; if (fin_cnt != 1) begin errors++; $display("FAIL swapped_finish got %0d want 1", fin_cnt); end
  endtask

  task automatic test_fill;
    sel = 1'b0;
    start_cmd(0, 0, 2, 1, 1'b1);
    collect(0, 0, -1);
    exp_q = '{pk(0,0), pk(1,0), pk(2,0), pk(0,1), pk(1,1), pk(2,1)};
    checks++; if (px_x.size() != exp_q.size()) begin errors++; $display("FAIL fill_count got %0d want %0d", px_x.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= px_x.size() || {px_x[i], px_y[i]} !== exp_q[i]) begin
        errors++; $display("FAIL fill_pix%0d got (%0d,%0d) want (%0d,%0d)", i, px_x[i], px_y[i], exp_q[i][15:8], exp_q[i][7:0]);
      end
    end
    checks++; if (fin_cnt != 1 || fin_cyc != last_xfer + 1) begin
      errors++; $display("FAIL fill_finish got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", fin_cnt, fin_cyc, last_xfer + 1);
    end
    sel = 1'b1;
    start_cmd(0, 0, 2, 1, 1'b1);
    collect(0, 0, -1);
    exp_q = '{pk(0,0), pk(1,0), pk(2,0), pk(2,1), pk(1,1), pk(0,1)};
    checks++; if (px_x.size() != exp_q.size()) begin errors++; $display("FAIL nofill_count got %0d want %0d", px_x.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= px_x.size() || {px_x[i], px_y[i]} !== exp_q[i]) begin
        errors++; $display("FAIL nofill_pix%0d got (%0d,%0d) want (%0d,%0d)", i, px_x[i], px_y[i], exp_q[i][15:8], exp_q[i][7:0]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_edge_stall;
    sel = 1'b0;
    start_cmd(254, 0, 255, 1, 1'b0);
    collect(2, 3, -1);
    exp_q = '{pk(254,0), pk(255,0), pk(255,1), pk(254,1)};
    checks++; if (px_x.size() != exp_q.size()) begin errors++; $display("FAIL edge_count got %0d want %0d", px_x.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= px_x.size() || {px_x[i], px_y[i]} !== exp_q[i]) begin
        errors++; $display("FAIL edge_pix%0d got (%0d,%0d) want (%0d,%0d)", i, px_x[i], px_y[i], exp_q[i][15:8], exp_q[i][7:0]);
      end
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL edge_stall_hold got %0d changes want 0", hold_bad); end
    checks++; if (fin_cnt != 1 || timed_out !== 1'b0) begin
      errors++; $display("FAIL edge_finish got cnt=%0d timeout=%0b want 1 0", fin_cnt, timed_out);
    end
  endtask

  task automatic test_degenerate;
    sel = 1'b0;
    start_cmd(7, 7, 7, 7, 1'b0);
    collect(0, 0, -1);
    checks++; if (px_x.size() != 1 || px_x[0] !== 8'd7 || px_y[0] !== 8'd7) begin
      errors++; $display("FAIL point_pix got n=%0d (%0d,%0d) want n=1 (7,7)", px_x.size(), px_x[0], px_y[0]);
    end
    checks++; if (fin_cnt != 1) begin errors++; $display("FAIL point_finish got %0d want 1", fin_cnt); end
    start_cmd(0, 4, 0, 6, 1'b0);
    collect(0, 0, -1);
    exp_q = '{pk(0,4), pk(0,5), pk(0,6)};
    checks++; if (px_x.size() != exp_q.size()) begin errors++; $display("FAIL line_count got %0d want %0d", px_x.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= px_x.size() || {px_x[i], px_y[i]} !== exp_q[i]) begin
        errors++; $display("FAIL line_pix%0d got (%0d,%0d) want (%0d,%0d)", i, px_x[i], px_y[i], exp_q[i][15:8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    sel = 1'b0;
    start_cmd(2, 3, 5, 5, 1'b0);
    collect(0, 0, 2);
    exp_q = '{pk(2,3), pk(3,3), pk(4,3), pk(5,3), pk(5,4), pk(5,5), pk(4,5), pk(3,5), pk(2,5), pk(2,4)};
    checks++; if (px_x.size() != exp_q.size()) begin errors++; $display("FAIL busy_start_count got %0d want %0d", px_x.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= px_x.size() || {px_x[i], px_y[i]} !== exp_q[i]) begin
        errors++; $display("FAIL busy_start_pix%0d got (%0d,%0d) want (%0d,%0d)", i, px_x[i], px_y[i], exp_q[i][15:8], exp_q[i][7:0]);
      end
    end
    checks++; if (fin_cnt != 1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL busy_start_finish got cnt=%0d busy_after=%0b want 1 0", fin_cnt, busy_after);
    end
  endtask

  task automatic test_reset_abort;
    int fin_seen;
    sel = 1'b0;
    ready = 1'b1;
    start_cmd(0, 0, 2, 1, 1'b1);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    checks++; if (pix0.PIX_VALID !== 1'b1 || pix0.X_Out !== 8'd2 || pix0.Y_Out !== 8'd0) begin
      errors++; $display("FAIL abort_third_pix got v=%0b (%0d,%0d) want v=1 (2,0)", pix0.PIX_VALID, pix0.X_Out, pix0.Y_Out);
    end
    RST = 1'b1;
    @(posedge ACLK); #1;
    RST = 1'b0;
    checks++; if (pix0.PIX_VALID !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got valid=%0b busy=%0b want 0 0", pix0.PIX_VALID, busy0);
    end
    fin_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (fin0 === 1'b1) fin_seen++;
      @(posedge ACLK); #1;
    end
    checks++; if (fin_seen != 0) begin errors++; $display("FAIL abort_no_finish got %0d pulses want 0", fin_seen); end
  endtask

  initial begin
    test_reset();
    test_outline();
    test_swapped();
    test_fill();
    test_edge_stall();
    test_degenerate();
    test_start_while_busy();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
